// File: rtl/msrv32_lsu_ctrl_if.sv
// Data-bus port of the msrv32 load/store unit: request/ack handshake plus address and data lanes.
// The LSU controller drives the master side, the memory/interconnect sits on the slave side.
interface msrv32_lsu_ctrl_if;
    logic [31:0] dbus_addr_out;
    logic [31:0] dbus_wdata_out;
    logic [3:0]  dbus_wr_mask_out;
    logic        dbus_rd_req_out;
    logic        dbus_wr_req_out;
    logic        dbus_ack_in;
    logic [31:0] dbus_rdata_in;

    modport master (
        output dbus_addr_out,
        output dbus_wdata_out,
        output dbus_wr_mask_out,
        output dbus_rd_req_out,
        output dbus_wr_req_out,
        input  dbus_ack_in,
        input  dbus_rdata_in
    );

    modport slave (
        input  dbus_addr_out,
        input  dbus_wdata_out,
        input  dbus_wr_mask_out,
        input  dbus_rd_req_out,
        input  dbus_wr_req_out,
        output dbus_ack_in,
        output dbus_rdata_in
    );
endinterface

// File: rtl/msrv32_lsu_ctrl.sv
// msrv32 load/store controller: one outstanding data-bus access, pipeline stall while in flight,
// byte-lane store formatting, load extraction/extension and request timeout.
module msrv32_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_n_in,
    input  logic                load_req_in,
    input  logic                store_req_in,
    input  logic [1:0]          load_size_in,
    input  logic                load_unsigned_in,
    input  logic [31:0]         addr_in,
    input  logic [31:0]         store_data_in,
    input  logic                flush_in,
    msrv32_lsu_ctrl_if.master   dbus,
    output logic                stall_out,
    output logic [31:0]         load_data_out,
    output logic                load_valid_out,
    output logic                bus_error_out
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      mask_q, mask_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            kill_q, kill_d;
    logic            rd_req_q, rd_req_d;
    logic            wr_req_q, wr_req_d;
    logic [31:0]     load_data_q, load_data_d;
    logic            load_valid_q, load_valid_d;
    logic            bus_error_q, bus_error_d;

    logic accepting, acc_load, acc_store, in_wait, killed;

    function automatic logic [31:0] extract(input logic [1:0] size, input logic uns,
                                            input logic [1:0] off, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract = word;
        endcase
    endfunction

    assign accepting = (state_q == StIdle) || (state_q == StResp);
    assign acc_load  = accepting && load_req_in && !flush_in;
    // The load wins a simultaneous load/store; the store is simply dropped.
    assign acc_store = accepting && !acc_load && store_req_in && !flush_in;
    assign in_wait   = (state_q == StRdWait) || (state_q == StWrWait);
    assign killed    = kill_q || flush_in;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        kill_d       = kill_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_error_d  = 1'b0;

        case (state_q)
            StIdle, StResp: begin
                state_d = StIdle;
                if (acc_load) begin
                    state_d  = StRdWait;
                    addr_d   = {addr_in[31:2], 2'b00};
                    size_d   = load_size_in;
                    uns_d    = load_unsigned_in;
                    off_d    = addr_in[1:0];
                    mask_d   = 4'b0000;
                    cnt_d    = '0;
                    kill_d   = 1'b0;
                    rd_req_d = 1'b1;
                end else if (acc_store) begin
                    state_d  = StWrWait;
                    addr_d   = {addr_in[31:2], 2'b00};
                    cnt_d    = '0;
                    kill_d   = 1'b0;
                    wr_req_d = 1'b1;
                    case (load_size_in)
                        2'b00: begin
                            mask_d  = 4'b0001 << addr_in[1:0];
                            wdata_d = {4{store_data_in[7:0]}};
                        end
                        2'b01: begin
                            mask_d  = 4'b0011 << {addr_in[1], 1'b0};
                            wdata_d = {2{store_data_in[15:0]}};
                        end
                        default: begin
                            mask_d  = 4'b1111;
                            wdata_d = store_data_in;
                        end
                    endcase
                end
            end
            StRdWait, StWrWait: begin
                kill_d = killed;
                if (dbus.dbus_ack_in) begin
                    state_d  = StResp;
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    if (state_q == StRdWait && !killed) begin
                        load_valid_d = 1'b1;
                        load_data_d  = extract(size_q, uns_q, off_q, dbus.dbus_rdata_in);
                    end
                end else if (cnt_q == CntLast) begin
                    state_d     = StResp;
                    rd_req_d    = 1'b0;
                    wr_req_d    = 1'b0;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            kill_q       <= kill_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign dbus.dbus_addr_out    = addr_q;
    assign dbus.dbus_wdata_out   = wdata_q;
    assign dbus.dbus_wr_mask_out = mask_q;
    assign dbus.dbus_rd_req_out  = rd_req_q;
    assign dbus.dbus_wr_req_out  = wr_req_q;

    assign stall_out      = in_wait || acc_load || acc_store;
    assign load_data_out  = load_data_q;
    assign load_valid_out = load_valid_q;
    assign bus_error_out  = bus_error_q;

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// Self-checking bench for msrv32_lsu_ctrl: per-feature tasks with a queue of expected load results.
module tb_msrv32_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic        store_req;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        flush;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_error;

    msrv32_lsu_ctrl_if dbus ();

    msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .load_req_in            (load_req),
        .store_req_in           (store_req),
        .load_size_in           (load_size),
        .load_unsigned_in       (load_unsigned),
        .addr_in                (addr),
        .store_data_in          (store_data),
        .flush_in               (flush),
        .dbus                   (dbus.master),
        .stall_out              (stall),
        .load_data_out          (load_data),
        .load_valid_out         (load_valid),
        .bus_error_out          (bus_error)
    );

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        load_req = 0; store_req = 0; flush = 0;
        dbus.dbus_ack_in = 0; dbus.dbus_rdata_in = 32'h0;
    endtask

    function automatic logic [31:0] m_load(logic [1:0] sz, logic u, logic [1:0] off,
                                           logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
        if (sz == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [3:0] m_mask(logic [1:0] sz, logic [1:0] off);
        if (sz == 2'b00) begin
            case (off)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    task automatic test_reset();
        sample();
        total++; if ({dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, stall, load_valid, bus_error} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, stall, load_valid, bus_error});
        else passed++;
        total++; if ({dbus.dbus_addr_out, dbus.dbus_wdata_out, dbus.dbus_wr_mask_out, load_data} !== 100'h0)
            $display("FAIL reset_data: got %h %h %h %h want zeros", dbus.dbus_addr_out,
                     dbus.dbus_wdata_out, dbus.dbus_wr_mask_out, load_data);
        else passed++;
        tick();
        rst_n = 1;
        last_load_data = 32'h0;
        // Ack while idle must be ignored.
        dbus.dbus_ack_in = 1; dbus.dbus_rdata_in = 32'hDEAD_BEEF;
        sample();
        total++; if ({dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, stall} !== 3'b0)
            $display("FAIL idle_ack_req: got %b want 000",
                     {dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, stall});
        else passed++;
        tick();
        idle_inputs();
        sample();
        total++; if ({load_valid, bus_error} !== 2'b0)
            $display("FAIL idle_ack_strobe: got %b want 00", {load_valid, bus_error});
        else passed++;
        tick();
    endtask

    task automatic test_lb(input logic uns, input logic [31:0] expected, input string nm);
        logic [31:0] e;
        load_req = 1; load_size = 2'b00; load_unsigned = uns; addr = 32'h0000_1003;
        exp_q.push_back(expected);
        sample();
        total++; if ({stall, dbus.dbus_rd_req_out} !== 2'b10)
            $display("FAIL %s_c0: got stall/req %b want 10", nm, {stall, dbus.dbus_rd_req_out});
        else passed++;
        tick();
        load_req = 0; addr = 32'hFFFF_FFFF;
        dbus.dbus_ack_in = 1; dbus.dbus_rdata_in = 32'h80FF_0000;
        sample();
        total++; if ({dbus.dbus_rd_req_out, stall, dbus.dbus_wr_mask_out} !== 6'b110000)
            $display("FAIL %s_c1: got req/stall/mask %b want 110000", nm,
                     {dbus.dbus_rd_req_out, stall, dbus.dbus_wr_mask_out});
        else passed++;
        total++; if (dbus.dbus_addr_out !== 32'h0000_1000)
            $display("FAIL %s_addr: got %h want 00001000", nm, dbus.dbus_addr_out);
        else passed++;
        tick();
        idle_inputs();
        sample();
        total++; if ({load_valid, stall, dbus.dbus_rd_req_out} !== 3'b100)
            $display("FAIL %s_c2: got valid/stall/req %b want 100", nm,
                     {load_valid, stall, dbus.dbus_rd_req_out});
        else passed++;
        total++;
        if (exp_q.size() == 0) $display("FAIL %s_data: got empty scoreboard want 1 entry", nm);
        else begin
            e = exp_q.pop_front();
            if (load_data !== e) $display("FAIL %s_data: got %h want %h", nm, load_data, e);
            else passed++;
            last_load_data = e;
        end
        tick();
    endtask

    task automatic test_sh();
        int n_stall = 0;
        int n_req   = 0;
        for (int c = 0; c < 6; c++) begin
            store_req = (c == 0); load_size = 2'b01; addr = 32'h0000_2002;
            store_data = 32'h1234_ABCD;
            dbus.dbus_ack_in = (c == 3);
            sample();
            if (stall) n_stall++;
            if (dbus.dbus_wr_req_out) n_req++;
            if (c == 1) begin
                total++; if (dbus.dbus_wr_mask_out !== 4'b1100)
                    $display("FAIL sh_mask: got %b want 1100", dbus.dbus_wr_mask_out);
                else passed++;
                total++; if (dbus.dbus_wdata_out !== 32'hABCD_ABCD)
                    $display("FAIL sh_wdata: got %h want abcdabcd", dbus.dbus_wdata_out);
                else passed++;
            end
            if (c == 4) begin
                total++; if (load_valid !== 1'b0)
                    $display("FAIL sh_no_valid: got %b want 0", load_valid);
                else passed++;
            end
            tick();
        end
        idle_inputs();
        total++; if (n_stall != 4) $display("FAIL sh_stall_cycles: got %0d want 4", n_stall);
        else passed++;
        total++; if (n_req != 3) $display("FAIL sh_req_cycles: got %0d want 3", n_req);
        else passed++;
    endtask

    task automatic test_timeout();
        int n_req = 0, n_err = 0, n_valid = 0, err_cyc = -1;
        logic err_stall = 1'b1;
        for (int c = 0; c < 8; c++) begin
            load_req = (c == 0); load_size = 2'b10; load_unsigned = 0; addr = 32'h0000_3000;
            sample();
            if (dbus.dbus_rd_req_out) n_req++;
            if (load_valid) n_valid++;
            if (bus_error) begin n_err++; err_cyc = c; err_stall = stall; end
            tick();
        end
        idle_inputs();
        total++; if (n_req != 4) $display("FAIL to_req_cycles: got %0d want 4", n_req);
        else passed++;
        total++; if (n_err != 1 || err_cyc != 5)
            $display("FAIL to_error: got count %0d cycle %0d want count 1 cycle 5", n_err, err_cyc);
        else passed++;
        total++; if (n_valid != 0) $display("FAIL to_no_valid: got %0d want 0", n_valid);
        else passed++;
        total++; if (err_stall !== 1'b0) $display("FAIL to_stall: got %b want 0", err_stall);
        else passed++;
        total++; if (load_data !== last_load_data)
            $display("FAIL to_load_data: got %h want %h", load_data, last_load_data);
        else passed++;
    endtask

    task automatic test_flush();
        int n_req = 0, n_valid = 0;
        logic req_c3 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            load_req = (c == 0); load_size = 2'b10; addr = 32'h0000_4000;
            flush = (c == 1);
            dbus.dbus_ack_in = (c == 3); dbus.dbus_rdata_in = $urandom;
            sample();
            if (dbus.dbus_rd_req_out) n_req++;
            if (c == 3) req_c3 = dbus.dbus_rd_req_out;
            if (load_valid) n_valid++;
            tick();
        end
        idle_inputs();
        total++; if (n_req != 3 || req_c3 !== 1'b1)
            $display("FAIL fl_req: got %0d cycles, c3 %b want 3 cycles, c3 1", n_req, req_c3);
        else passed++;
        total++; if (n_valid != 0) $display("FAIL fl_no_valid: got %0d want 0", n_valid);
        else passed++;
        total++; if (load_data !== last_load_data)
            $display("FAIL fl_load_data: got %h want %h", load_data, last_load_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, e;
        rd = $urandom;
        // c0: load and store together, load wins.
        load_req = 1; store_req = 1; load_size = 2'b10; load_unsigned = 0;
        addr = 32'h0000_5004; store_data = 32'h5555_AAAA;
        exp_q.push_back(rd);
        sample();
        tick();
        idle_inputs();
        dbus.dbus_ack_in = 1; dbus.dbus_rdata_in = rd;
        sample();
        total++; if ({dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, dbus.dbus_wr_mask_out} !== 6'b100000)
            $display("FAIL both_c1: got rd/wr/mask %b want 100000",
                     {dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, dbus.dbus_wr_mask_out});
        else passed++;
        tick();
        // c2: RESP of the LW, SW presented here.
        idle_inputs();
        store_req = 1; load_size = 2'b10; addr = 32'h0000_6008; store_data = 32'hCAFE_F00D;
        sample();
        total++; if ({load_valid, stall, dbus.dbus_rd_req_out, dbus.dbus_wr_req_out} !== 4'b1100)
            $display("FAIL b2b_c2: got valid/stall/rd/wr %b want 1100",
                     {load_valid, stall, dbus.dbus_rd_req_out, dbus.dbus_wr_req_out});
        else passed++;
        total++;
        if (exp_q.size() == 0) $display("FAIL b2b_data: got empty scoreboard want 1 entry");
        else begin
            e = exp_q.pop_front();
            if (load_data !== e) $display("FAIL b2b_data: got %h want %h", load_data, e);
            else passed++;
            last_load_data = e;
        end
        tick();
        idle_inputs();
        dbus.dbus_ack_in = 1;
        sample();
        total++; if ({dbus.dbus_wr_req_out, dbus.dbus_wr_mask_out} !== 5'b11111 ||
                     dbus.dbus_wdata_out !== 32'hCAFE_F00D || dbus.dbus_addr_out !== 32'h0000_6008)
            $display("FAIL b2b_sw: got req/mask %b wdata %h addr %h want 11111 cafef00d 00006008",
                     {dbus.dbus_wr_req_out, dbus.dbus_wr_mask_out}, dbus.dbus_wdata_out,
                     dbus.dbus_addr_out);
        else passed++;
        tick();
        idle_inputs();
        sample();
        total++; if ({dbus.dbus_wr_req_out, stall, load_valid} !== 3'b000)
            $display("FAIL b2b_end: got wr/stall/valid %b want 000",
                     {dbus.dbus_wr_req_out, stall, load_valid});
        else passed++;
        tick();
    endtask

    task automatic test_load_extract();
        logic [31:0] rd, e;
        for (int sz = 0; sz < 3; sz++) begin
            for (int off = 0; off < 4; off++) begin
                if ((sz == 1 && off[0]) || (sz == 2 && off != 0)) continue;
                for (int u = 0; u < 2; u++) begin
                    rd = $urandom;
                    load_req = 1; load_size = 2'(sz); load_unsigned = u[0];
                    addr = 32'h0000_7000 | 32'(off);
                    exp_q.push_back(m_load(2'(sz), u[0], 2'(off), rd));
                    sample();
                    tick();
                    idle_inputs();
                    dbus.dbus_ack_in = 1; dbus.dbus_rdata_in = rd;
                    sample();
                    total++; if (dbus.dbus_addr_out !== 32'h0000_7000)
                        $display("FAIL ld_addr sz%0d off%0d: got %h want 00007000", sz, off,
                                 dbus.dbus_addr_out);
                    else passed++;
                    tick();
                    idle_inputs();
                    sample();
                    total++;
                    if (exp_q.size() == 0 || load_valid !== 1'b1)
                        $display("FAIL ld_ext sz%0d off%0d u%0d: got valid %b, %0d queued want 1, 1",
                                 sz, off, u, load_valid, exp_q.size());
                    else begin
                        e = exp_q.pop_front();
                        if (load_data !== e)
                            $display("FAIL ld_ext sz%0d off%0d u%0d: got %h want %h", sz, off, u,
                                     load_data, e);
                        else passed++;
                        last_load_data = e;
                    end
                    tick();
                end
            end
        end
    endtask

    task automatic test_store_format();
        logic [31:0] d;
        for (int sz = 0; sz < 3; sz++) begin
            for (int off = 0; off < 4; off++) begin
                if ((sz == 1 && off[0]) || (sz == 2 && off != 0)) continue;
                d = $urandom;
                store_req = 1; load_size = 2'(sz); addr = 32'h0000_A000 | 32'(off);
                store_data = d;
                sample();
                tick();
                idle_inputs();
                dbus.dbus_ack_in = 1;
                sample();
                total++; if (dbus.dbus_wr_mask_out !== m_mask(2'(sz), 2'(off)) ||
                             dbus.dbus_wdata_out !== m_wdata(2'(sz), d))
                    $display("FAIL st_fmt sz%0d off%0d: got mask %b wdata %h want %b %h", sz, off,
                             dbus.dbus_wr_mask_out, dbus.dbus_wdata_out, m_mask(2'(sz), 2'(off)),
                             m_wdata(2'(sz), d));
                else passed++;
                tick();
                idle_inputs();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, e;
        store_req = 1; load_size = 2'b10; addr = 32'h0000_8000; store_data = 32'h1111_2222;
        sample();
        tick();
        idle_inputs();
        sample();
        total++; if (dbus.dbus_wr_req_out !== 1'b1)
            $display("FAIL rm_pre: got wr_req %b want 1", dbus.dbus_wr_req_out);
        else passed++;
        tick();
        #2 rst_n = 0;
        #1;
        total++; if ({dbus.dbus_wr_req_out, stall} !== 2'b00)
            $display("FAIL rm_async: got wr/stall %b want 00", {dbus.dbus_wr_req_out, stall});
        else passed++;
        tick();
        rst_n = 1;
        last_load_data = 32'h0;
        sample();
        total++; if ({dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, stall, load_valid, bus_error} !== 5'b0 ||
                     load_data !== 32'h0)
            $display("FAIL rm_idle: got ctl %b data %h want 00000 0",
                     {dbus.dbus_rd_req_out, dbus.dbus_wr_req_out, stall, load_valid, bus_error},
                     load_data);
        else passed++;
        tick();
        rd = $urandom;
        load_req = 1; load_size = 2'b01; load_unsigned = 0; addr = 32'h0000_9002;
        exp_q.push_back(m_load(2'b01, 1'b0, 2'd2, rd));
        sample();
        tick();
        idle_inputs();
        dbus.dbus_ack_in = 1; dbus.dbus_rdata_in = rd;
        sample();
        tick();
        idle_inputs();
        sample();
        total++;
        if (exp_q.size() == 0 || load_valid !== 1'b1)
            $display("FAIL rm_load: got valid %b, %0d queued want 1, 1", load_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (load_data !== e) $display("FAIL rm_load: got %h want %h", load_data, e);
            else passed++;
        end
        tick();
    endtask

    initial begin
        rst_n = 0;
        load_size = 0; load_unsigned = 0; addr = 0; store_data = 0;
        idle_inputs();
        test_reset();
        test_lb(1'b0, 32'hFFFF_FF80, "lb");
        test_lb(1'b1, 32'h0000_0080, "lbu");
        test_sh();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_load_extract();
        test_store_format();
        test_reset_mid();
        total++; if (exp_q.size() != 0)
            $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
